// File: rtl/mc_main_fsm.sv
// Multicycle MIPS main controller: steps each instruction through fetch, decode,
// execute, memory and writeback states and decodes datapath selects and strobes.
module mc_main_fsm #(
  parameter int unsigned EN_BNE          = 1,
  parameter int unsigned MEM_HANDSHAKE   = 1,
  parameter int unsigned TRAP_ON_ILLEGAL = 1,
  parameter int unsigned STATE_W         = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op_i6,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic               branch,
  output logic               branch_ne,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic               mem_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP,
    S_TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t r_state;
  state_t w_next;

  logic w_rdy;
  logic w_is_bne;
  logic w_mem_req;
  logic w_ir_write;
  logic w_pc_write;
  logic w_branch;
  logic w_branch_ne;
  logic w_mem_write;
  logic w_reg_write;

  assign w_rdy    = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign w_is_bne = (EN_BNE != 0) && (op_i6 == OP_BNE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_mem_req   = 1'b0;
    iord        = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_branch    = 1'b0;
    w_branch_ne = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    pc_src      = 2'b00;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    illegal_op  = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        alu_src_b  = 2'b01;
        w_ir_write = w_rdy;
        w_pc_write = w_rdy;
        if (w_rdy) begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (op_i6 == OP_RTYPE) begin
          w_next = S_EXECUTE;
        end else if ((op_i6 == OP_LW) || (op_i6 == OP_SW)) begin
          w_next = S_MEMADR;
        end else if ((op_i6 == OP_BEQ) || w_is_bne) begin
          w_next = S_BRANCH;
        end else if (op_i6 == OP_ADDI) begin
          w_next = S_ADDIEX;
        end else if (op_i6 == OP_J) begin
          w_next = S_JUMP;
        end else begin
          w_next = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
        end
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // The IR holds the opcode for the whole instruction, so re-decode here.
        w_next    = (op_i6 == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        iord      = 1'b1;
        if (w_rdy) begin
          w_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        w_reg_write = 1'b1;
        mem_to_reg  = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_req   = 1'b1;
        iord        = 1'b1;
        w_mem_write = 1'b1;
        if (w_rdy) begin
          w_next = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        reg_dst     = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_op      = 2'b01;
        pc_src      = 2'b01;
        w_branch    = (op_i6 == OP_BEQ);
        w_branch_ne = w_is_bne;
        w_next      = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        w_pc_write = 1'b1;
        w_next     = S_FETCH;
      end
      S_TRAP: begin
        illegal_op = 1'b1;
        w_next     = S_TRAP;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Strobes are gated by rst_n so nothing fires between reset assertion and the
  // asynchronous state clear settling.
  assign mem_req   = w_mem_req   & rst_n;
  assign ir_write  = w_ir_write  & rst_n;
  assign pc_write  = w_pc_write  & rst_n;
  assign branch    = w_branch    & rst_n;
  assign branch_ne = w_branch_ne & rst_n;
  assign mem_write = w_mem_write & rst_n;
  assign reg_write = w_reg_write & rst_n;

  assign state_o = r_state;

endmodule
